// File: rtl/rtf_uart_pkg.sv
// Shared constants for the UART receive interrupt block: interrupt cause IDs
// and line status register bit positions.
package rtf_uart_pkg;

  typedef enum logic [2:0] {
    IRQ_NONE = 3'b000,
    IRQ_RDA  = 3'b100,
    IRQ_CTO  = 3'b101,
    IRQ_RLS  = 3'b110
  } irq_id_e;

  localparam int unsigned LSR_DR  = 0;
  localparam int unsigned LSR_OE  = 1;
  localparam int unsigned LSR_PE  = 2;
  localparam int unsigned LSR_FE  = 3;
  localparam int unsigned LSR_BI  = 4;
  localparam int unsigned LSR_TO  = 5;
  localparam int unsigned LSR_THR = 6;
  localparam int unsigned LSR_ERR = 7;

endpackage

// File: rtl/rtf_uart_rx_timeout.sv
// Character-timeout counter: counts baud16x ticks while the FIFO sits idle
// and non-empty, saturating at to_chars * frame_size.
module rtf_uart_rx_timeout #(
  parameter int unsigned QCNT_W = 6,
  parameter int unsigned TO_W   = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud16x_ce,
  input  logic [2:0]        to_chars,
  input  logic [9:0]        frame_size,
  input  logic [QCNT_W-1:0] qcnt,
  input  logic              empty,
  input  logic              rx_rd,
  output logic              timeout
);

  logic [TO_W-1:0]   limit;
  logic [TO_W-1:0]   cnt;
  logic [QCNT_W-1:0] qcnt_q;
  logic              reload;

  assign limit  = TO_W'(to_chars) * TO_W'(frame_size);
  // A change in occupancy means a new word arrived (or was popped): restart.
  assign reload = rx_rd | empty | (qcnt != qcnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      qcnt_q  <= '0;
      timeout <= 1'b0;
    end else begin
      qcnt_q <= qcnt;
      if (reload) begin
        cnt     <= '0;
        timeout <= 1'b0;
      end else begin
        // Clamp rather than hold so a shrinking limit still lands on a match.
        if (baud16x_ce)
          cnt <= (cnt >= limit) ? limit : cnt + TO_W'(1);
        if ((cnt == limit) && (limit != '0) && !empty)
          timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtf_uart_rx_irq.sv
// Receive interrupt controller: sticky LSR, prioritised irq/irq_id, timeout.
// Optional receive-interrupt holdoff enabled by RTF_UART_RX_IRQ_HOLDOFF_EN.
module rtf_uart_rx_irq
  import rtf_uart_pkg::*;
#(
  parameter int unsigned QCNT_W = 6,
  parameter int unsigned TO_W   = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud16x_ce,
  input  logic [2:0]        ier,
  input  logic [QCNT_W-1:0] rx_thresh,
  input  logic [2:0]        to_chars,
  input  logic [9:0]        frame_size,
  input  logic [QCNT_W-1:0] qcnt,
  input  logic              empty,
  input  logic              rx_rd,
  input  logic              frame_err,
  input  logic              parity_err,
  input  logic              break_det,
  input  logic              overrun,
  input  logic              lsr_rd,
`ifdef RTF_UART_RX_IRQ_HOLDOFF_EN
  input  logic [7:0]        holdoff,
`endif
  output logic              irq,
  output logic [2:0]        irq_id,
  output logic [7:0]        lsr,
  output logic              timeout
);

  logic              overrun_q;
  logic              oe, pe, fe, bi;
  logic              err, thr, mask;
  logic [QCNT_W-1:0] thr_eff;
  irq_id_e           next_id;

  rtf_uart_rx_timeout #(
    .QCNT_W (QCNT_W),
    .TO_W   (TO_W)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud16x_ce (baud16x_ce),
    .to_chars   (to_chars),
    .frame_size (frame_size),
    .qcnt       (qcnt),
    .empty      (empty),
    .rx_rd      (rx_rd),
    .timeout    (timeout)
  );

  // Sticky error bits: a new set in the same cycle as lsr_rd survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
      oe        <= 1'b0;
      pe        <= 1'b0;
      fe        <= 1'b0;
      bi        <= 1'b0;
    end else begin
      overrun_q <= overrun;
      oe <= (oe & ~lsr_rd) | (overrun & ~overrun_q);
      pe <= (pe & ~lsr_rd) | (~empty & parity_err);
      fe <= (fe & ~lsr_rd) | (~empty & frame_err);
      bi <= (bi & ~lsr_rd) | (~empty & break_det);
    end
  end

  assign err     = oe | pe | fe | bi;
  assign thr_eff = (rx_thresh == '0) ? QCNT_W'(1) : rx_thresh;
  assign thr     = ~empty & (qcnt >= thr_eff);

  always_comb begin
    lsr          = '0;
    lsr[LSR_DR]  = ~empty;
    lsr[LSR_OE]  = oe;
    lsr[LSR_PE]  = pe;
    lsr[LSR_FE]  = fe;
    lsr[LSR_BI]  = bi;
    lsr[LSR_TO]  = timeout;
    lsr[LSR_THR] = thr;
    lsr[LSR_ERR] = err;
  end

  always_comb begin
    next_id = IRQ_NONE;
    if (ier[2] && err)
      next_id = IRQ_RLS;
    else if (ier[0] && thr && !mask)
      next_id = IRQ_RDA;
    else if (ier[1] && timeout && !mask)
      next_id = IRQ_CTO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq    <= 1'b0;
      irq_id <= IRQ_NONE;
    end else begin
      irq    <= (next_id != IRQ_NONE);
      irq_id <= next_id;
    end
  end

`ifdef RTF_UART_RX_IRQ_HOLDOFF_EN
  logic [11:0] ho_cnt;

  // Armed on the cycle irq is about to fall; counts down in baud16x ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ho_cnt <= '0;
    else if (irq && (next_id == IRQ_NONE))
      ho_cnt <= {holdoff, 4'b0000};
    else if (baud16x_ce && (ho_cnt != '0))
      ho_cnt <= ho_cnt - 12'd1;
  end

  assign mask = (ho_cnt != '0);
`else
  assign mask = 1'b0;
`endif

endmodule

// File: tb/tb_rtf_uart_rx_irq.sv
// Directed bench for rtf_uart_rx_irq with a scoreboard of expected values.
// Holdoff steps compile in only with RTF_UART_RX_IRQ_HOLDOFF_EN.
module tb_rtf_uart_rx_irq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud16x_ce;
  logic [2:0] ier;
  logic [5:0] rx_thresh;
  logic [2:0] to_chars;
  logic [9:0] frame_size;
  logic [5:0] qcnt;
  logic       empty;
  logic       rx_rd;
  logic       frame_err, parity_err, break_det, overrun, lsr_rd;
`ifdef RTF_UART_RX_IRQ_HOLDOFF_EN
  logic [7:0] holdoff;
`endif
  logic       irq;
  logic [2:0] irq_id;
  logic [7:0] lsr;
  logic       timeout;

  rtf_uart_rx_irq #(
    .QCNT_W (6),
    .TO_W   (13)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud16x_ce (baud16x_ce),
    .ier        (ier),
    .rx_thresh  (rx_thresh),
    .to_chars   (to_chars),
    .frame_size (frame_size),
    .qcnt       (qcnt),
    .empty      (empty),
    .rx_rd      (rx_rd),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .break_det  (break_det),
    .overrun    (overrun),
    .lsr_rd     (lsr_rd),
`ifdef RTF_UART_RX_IRQ_HOLDOFF_EN
    .holdoff    (holdoff),
`endif
    .irq        (irq),
    .irq_id     (irq_id),
    .lsr        (lsr),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic [15:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic pop_check(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      baud16x_ce = 1'b1;
      cyc(1);
      baud16x_ce = 1'b0;
      cyc(1);
    end
  endtask

  initial begin
    rst_n = 1'b0; baud16x_ce = 1'b0; ier = 3'b000; rx_thresh = 6'd4;
    to_chars = 3'd0; frame_size = 10'd160; qcnt = 6'd0; empty = 1'b1;
    rx_rd = 1'b0; frame_err = 1'b0; parity_err = 1'b0; break_det = 1'b0;
    overrun = 1'b0; lsr_rd = 1'b0;
`ifdef RTF_UART_RX_IRQ_HOLDOFF_EN
    holdoff = 8'd0;
`endif
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // Post-reset state
    push("rst_irq", 16'd0);     pop_check(16'(irq));
    push("rst_irq_id", 16'd0);  pop_check(16'(irq_id));
    push("rst_lsr", 16'h00);    pop_check(16'(lsr));
    push("rst_timeout", 16'd0); pop_check(16'(timeout));

    // Threshold interrupt at qcnt=4
    ier = 3'b001; empty = 1'b0;
    for (int q = 1; q <= 3; q++) begin
      qcnt = 6'(q);
      cyc(1);
    end
    push("thr_below_id", 16'd0); pop_check(16'(irq_id));
    qcnt = 6'd4;
    #1;
    push("thr_lsr6_comb", 16'd1);  pop_check(16'(lsr[6]));
    push("thr_irq_latency", 16'd0); pop_check(16'(irq));
    cyc(1);
    push("thr_irq_id", 16'h4); pop_check(16'(irq_id));
    push("thr_irq", 16'd1);    pop_check(16'(irq));
    rx_rd = 1'b1; qcnt = 6'd3;
    cyc(1);
    rx_rd = 1'b0;
    push("thr_rd_irq", 16'd0); pop_check(16'(irq));

    // Threshold 0 behaves as 1; full FIFO wraps qcnt to 0
    rx_thresh = 6'd0; qcnt = 6'd1;
    #1;
    push("thr_zero_as_one", 16'd1); pop_check(16'(lsr[6]));
    rx_thresh = 6'd4; qcnt = 6'd0;
    #1;
    push("wrap_dr", 16'd1);  pop_check(16'(lsr[0]));
    push("wrap_thr", 16'd0); pop_check(16'(lsr[6]));

    // Character timeout: 4 chars * 160 ticks
    ier = 3'b010; to_chars = 3'd4; frame_size = 10'd160; qcnt = 6'd1;
    cyc(2);
    tick(639);
    push("to_before", 16'd0); pop_check(16'(timeout));
    tick(1);
    push("to_fire", 16'd1);   pop_check(16'(timeout));
    push("to_lsr5", 16'd1);   pop_check(16'(lsr[5]));
    cyc(1);
    push("to_irq_id", 16'h5); pop_check(16'(irq_id));
    rx_rd = 1'b1;
    cyc(1);
    rx_rd = 1'b0;
    push("to_rd_clear", 16'd0); pop_check(16'(timeout));
    cyc(1);
    push("to_rd_irq", 16'd0);   pop_check(16'(irq));
    to_chars = 3'd0;
    tick(700);
    push("to_disabled", 16'd0);     pop_check(16'(timeout));
    push("to_disabled_irq", 16'd0); pop_check(16'(irq));

    // Line status has priority over threshold and timeout
    ier = 3'b111; rx_thresh = 6'd1; to_chars = 3'd1; frame_size = 10'd16;
    tick(20);
    push("prio_to_set", 16'd1);  pop_check(16'(timeout));
    push("prio_thr_id", 16'h4);  pop_check(16'(irq_id));
    parity_err = 1'b1;
    cyc(1);
    parity_err = 1'b0;
    cyc(1);
    push("prio_rls_id", 16'h6); pop_check(16'(irq_id));
    push("prio_pe", 16'd1);     pop_check(16'(lsr[2]));
    push("prio_err", 16'd1);    pop_check(16'(lsr[7]));
    lsr_rd = 1'b1; parity_err = 1'b1;
    cyc(1);
    lsr_rd = 1'b0; parity_err = 1'b0;
    push("pe_set_wins", 16'd1); pop_check(16'(lsr[2]));
    lsr_rd = 1'b1;
    cyc(1);
    lsr_rd = 1'b0;
    push("pe_cleared", 16'd0);  pop_check(16'(lsr[2]));
    push("err_cleared", 16'd0); pop_check(16'(lsr[7]));
    cyc(1);
    push("rls_removed_id", 16'h4); pop_check(16'(irq_id));

    // Overrun edge capture
    ier = 3'b100;
    for (int i = 0; i < 10; i++) begin
      overrun = 1'b1;
      lsr_rd  = (i == 5);
      cyc(1);
      if (i == 0) begin push("oe_rise", 16'd1);   pop_check(16'(lsr[1])); end
      if (i == 4) begin push("oe_hold", 16'd1);   pop_check(16'(lsr[1])); end
      if (i == 5) begin push("oe_clear", 16'd0);  pop_check(16'(lsr[1])); end
      if (i == 9) begin push("oe_no_reset", 16'd0); pop_check(16'(lsr[1])); end
    end
    lsr_rd = 1'b0; overrun = 1'b0;
    cyc(1);
    overrun = 1'b1;
    cyc(1);
    push("oe_second_rise", 16'd1); pop_check(16'(lsr[1]));
    cyc(1);
    push("oe_irq", 16'd1); pop_check(16'(irq));

    // Asynchronous reset mid-operation (receiver resets alongside)
    rst_n = 1'b0; empty = 1'b1; qcnt = 6'd0; overrun = 1'b0;
    #1;
    push("arst_irq", 16'd0);     pop_check(16'(irq));
    push("arst_irq_id", 16'd0);  pop_check(16'(irq_id));
    push("arst_lsr", 16'h00);    pop_check(16'(lsr));
    push("arst_timeout", 16'd0); pop_check(16'(timeout));
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

`ifdef RTF_UART_RX_IRQ_HOLDOFF_EN
    // Holdoff masks THR for 2*16 ticks after irq falls; RLS is never masked
    holdoff = 8'd2; ier = 3'b101; rx_thresh = 6'd4; to_chars = 3'd0;
    empty = 1'b0; qcnt = 6'd4;
    cyc(2);
    push("ho_irq_on", 16'd1); pop_check(16'(irq));
    rx_rd = 1'b1; qcnt = 6'd3;
    cyc(1);
    rx_rd = 1'b0;
    push("ho_irq_fall", 16'd0); pop_check(16'(irq));
    qcnt = 6'd4;
    cyc(2);
    tick(31);
    push("ho_masked", 16'd0); pop_check(16'(irq));
    tick(1);
    push("ho_expired", 16'd1); pop_check(16'(irq));
    rx_rd = 1'b1; qcnt = 6'd3;
    cyc(1);
    rx_rd = 1'b0; qcnt = 6'd4;
    push("ho_fall2", 16'd0); pop_check(16'(irq));
    parity_err = 1'b1;
    cyc(1);
    parity_err = 1'b0;
    cyc(1);
    push("ho_rls_unmasked", 16'h6); pop_check(16'(irq_id));
`endif

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtf_uart_rx_irq.md
Name: rtf_uart_rx_irq

Overview:
- Downstream consumer of the UART receiver's FIFO status and line-error outputs.
- Produces a prioritised receive interrupt, a sticky line-status register (LSR) and a character-timeout indication for the bus/register block.
- Runs its own character-timeout counter on the receiver's baud16x clock enable.
- Decouples interrupt policy from the receive datapath.

Parameters:
- QCNT_W, 6: width of the receiver FIFO occupancy count (64-entry FIFO).
- TO_W, 13: width of the timeout counter; holds 7 * 1023.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- baud16x_ce  in  1  16x baud clock enable (same as receiver)
- ier  in  3  enables: [0] threshold, [1] timeout, [2] line status
- rx_thresh  in  QCNT_W  FIFO level threshold; 0 is treated as 1
- to_chars  in  3  timeout length in character times; 0 disables timeout
- frame_size  in  10  frame length in baud16x ticks
- qcnt  in  QCNT_W  receiver FIFO occupancy
- empty  in  1  receiver FIFO empty
- rx_rd  in  1  FIFO pop strobe (bus read of receive data)
- frame_err, parity_err, break_det  in  1 each  head-of-FIFO error flags; valid when !empty
- overrun  in  1  receiver overrun level
- lsr_rd  in  1  one-cycle strobe; clears sticky LSR bits
- irq  out  1  interrupt request, registered
- irq_id  out  3  interrupt cause, registered
- lsr  out  8  line status register
- timeout  out  1  character timeout flag

Behaviour:
- Reset (async, rst_n=0): irq=0, irq_id=3'b000, all sticky bits=0, timeout=0, timeout counter=0. The same values apply on reset mid-operation.
- Sticky error capture, each clk:
  - PE set when !empty & parity_err; FE when !empty & frame_err; BI when !empty & break_det.
  - OE set on a rising edge of overrun (1-cycle delayed copy).
  - All four clear on lsr_rd. If set and clear occur in the same cycle, set wins.
- LSR bit map: [0] DR = !empty; [1] OE; [2] PE; [3] FE; [4] BI; [5] timeout; [6] THR = level reached; [7] ERR = OE|PE|FE|BI.
- Level reached: !empty & (qcnt >= max(rx_thresh,1)). Comparison is unsigned at QCNT_W bits.
- Timeout counter:
  - limit = to_chars * frame_size, computed unsigned at TO_W bits.
  - Counter reloads to 0 on rx_rd, when empty, or when qcnt differs from its value in the previous cycle (new word written).
  - Otherwise it increments on baud16x_ce, saturating at limit.
  - timeout is set when counter == limit & limit != 0 & !empty. It clears on a counter reload.
  - Reload has priority over increment.
- Interrupt priority, evaluated every clk, registered output (1-cycle latency from cause to irq/irq_id):
  - 3'b110: ier[2] & ERR
  - 3'b100: else ier[0] & THR
  - 3'b101: else ier[1] & timeout
  - 3'b000: none
  - irq = (irq_id != 0).
- Interrupt removal: reading data (rx_rd) lowers THR/timeout causes naturally; lsr_rd clears the line-status cause. irq drops 1 cycle after its cause disappears.
- Boundary cases:
  - qcnt wraps to 0 when full with 64 entries: use !empty, not qcnt, for DR.
  - frame_size change mid-count takes effect on the next compare.
  - Simultaneous rx_rd and a qcnt change: single reload, no double action.

Optional Feature:
- Macro: RTF_UART_RX_IRQ_HOLDOFF_EN.
- With the macro:
  - Adds input port holdoff [7:0].
  - After irq falls, THR and timeout causes are masked for holdoff*16 baud16x_ce ticks, using an 12-bit down-counter. Line-status causes are never masked.
  - holdoff=0 gives no masking.
  - The down-counter resets to 0.
- Without the macro: no holdoff port, no counter; causes are reported immediately.

Decomposition:
- Package rtf_uart_pkg holds:
  - IRQ ID constants IRQ_NONE=3'b000, IRQ_RLS=3'b110, IRQ_RDA=3'b100, IRQ_CTO=3'b101.
  - LSR bit index constants LSR_DR..LSR_ERR.
- One sub-module, rtf_uart_rx_timeout: the reloadable saturating timeout counter, limit multiply and timeout flag.

Test Plan:
- Reset: assert rst_n=0 mid-count with irq high -> irq=0, irq_id=000, lsr=8'h00 immediately (async).
- Threshold: rx_thresh=4, ier=3'b001, qcnt steps 0..4 with empty=0 -> irq_id=100 one cycle after qcnt=4. rx_rd pulse with qcnt going to 3 -> irq=0 next cycle.
- Timeout: frame_size=160, to_chars=4, qcnt=1 held, ier=3'b010 -> timeout after 640 baud16x_ce ticks, irq_id=101. rx_rd resets; to_chars=0 never fires.
- Line status priority: THR and timeout active, parity_err=1 with !empty, ier=3'b111 -> irq_id=110, lsr[2]=1, lsr[7]=1. lsr_rd and parity_err in the same cycle -> PE stays 1.
- Overrun edge: overrun held high 10 cycles, lsr_rd at cycle 5 -> OE clears and does not re-set until the next rising edge.
- HOLDOFF_EN: holdoff=2, THR re-asserts immediately after irq falls -> irq stays low for 32 ticks. A parity error during holdoff -> irq_id=110 at once.
